sm_mac_pipe: RTL and testbench



---
 rtl/sm_mac_pipe_pkg.sv | 38 +++
 rtl/sm_mac_pipe_if.sv | 26 ++
 rtl/sm_mac_pipe_mul_lane.sv | 47 ++++
 rtl/sm_mac_pipe.sv | 158 +++++++++++++++
 tb/tb_sm_mac_pipe.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_mac_pipe_pkg.sv
// Shared types and helper functions for the sign-magnitude MAC pipeline.
// The helpers work on a 64-bit container word so that every parametrised width can use them.
package sm_pkg;

  localparam int MAX_W  = 64;
  localparam int DEF_W  = 16;
  localparam int PROD_W = 2*DEF_W-2;

  typedef logic [MAX_W-1:0] word_t;

  // First cause of overflow seen in a vector; kept for debug visibility.
  typedef enum logic [1:0] {
    OVF_NONE  = 2'd0,
    OVF_UNITY = 2'd1,
    OVF_ACC   = 2'd2,
    OVF_OUT   = 2'd3
  } ovf_reason_t;

  // Code {1,0..0} of a w-bit operand, which stands for +1.0.
  function automatic word_t sm_unity(input int w);
    return word_t'(1) << (w - 1);
  endfunction

  function automatic word_t sm_to_tc(input logic sign, input word_t mag);
    return sign ? (~mag + word_t'(1)) : mag;
  endfunction

  // Two's complement to sign-magnitude with a mag_w-bit magnitude; result sign sits at bit mag_w.
  function automatic word_t sat_tc_to_sm(input word_t v, input int mag_w, output logic sat);
    word_t lim;
    word_t abs_v;
    lim   = (word_t'(1) << mag_w) - word_t'(1);
    abs_v = v[MAX_W-1] ? (~v + word_t'(1)) : v;
    sat   = (abs_v > lim);
    return (word_t'(v[MAX_W-1]) << mag_w) | (sat ? lim : abs_v);
  endfunction

endpackage

// File: rtl/sm_mac_pipe_if.sv
// Operand stream and result handshake of the MAC engine.
interface sm_mac_pipe_if #(
  parameter int W     = 16,
  parameter int LANES = 1
);
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-2:0]     out_sum;
  logic               out_ovf;

  modport master (
    output in_valid, in_last, in_a, in_b, relu_en, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b, relu_en, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/sm_mac_pipe_mul_lane.sv
// One lane's sign-magnitude product with zero and unity (+1.0) code handling.
module sm_mul_lane
  import sm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_sign,
  output logic [2*W-3:0] o_mag,
  output logic           o_ovf
);
  localparam int            PW    = 2*W-2;
  localparam logic [W-1:0]  UNITY = W'(sm_unity(W));

  logic          w_a_zero, w_b_zero, w_a_unity, w_b_unity;
  logic [PW-1:0] w_prod;

  assign w_a_zero  = (i_a == '0);
  assign w_b_zero  = (i_b == '0);
  assign w_a_unity = (i_a == UNITY);
  assign w_b_unity = (i_b == UNITY);
  assign w_prod    = PW'(i_a[W-2:0]) * PW'(i_b[W-2:0]);

  always_comb begin
    o_sign = 1'b0;
    o_mag  = '0;
    o_ovf  = 1'b0;
    if (w_a_zero || w_b_zero) begin
      o_mag = '0;
    end else if (w_a_unity && w_b_unity) begin
      // 1.0 x 1.0 is not representable; clip to the largest fraction.
      o_mag = '1;
      o_ovf = 1'b1;
    end else if (w_a_unity) begin
      o_sign = i_b[W-1];
      o_mag  = {i_b[W-2:0], {(W-1){1'b0}}};
    end else if (w_b_unity) begin
      o_sign = i_a[W-1];
      o_mag  = {i_a[W-2:0], {(W-1){1'b0}}};
    end else begin
      o_sign = i_a[W-1] ^ i_b[W-1];
      o_mag  = w_prod;
    end
    if (o_mag == '0) o_sign = 1'b0;
  end
endmodule

// File: rtl/sm_mac_pipe.sv
// Sign-magnitude dot-product engine: S1 lane products, S2 lane sum, S3 accumulate,
// then a saturating sign-magnitude output register with optional ReLU.
module sm_mac_pipe
  import sm_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 1,
  parameter int ACC_W = 40
) (
  input logic          clk,
  input logic          rst,
  sm_mac_pipe_if.slave bus
);
  localparam int PW  = 2*W-2;
  localparam int PW1 = PW+1;
  localparam logic signed [ACC_W:0] P_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] P_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  logic                    w_en;
  logic [LANES-1:0]        w_l_sign, w_l_ovf;
  logic [PW-1:0]           w_l_mag [LANES];

  logic                    r_s1_valid, r_s1_last, r_s1_relu, r_s1_ovf;
  logic [LANES-1:0]        r_s1_sign;
  logic [PW-1:0]           r_s1_mag [LANES];

  logic signed [ACC_W-1:0] w_s2_sum, r_s2_sum;
  logic                    r_s2_valid, r_s2_last, r_s2_relu, r_s2_ovf;

  logic signed [ACC_W:0]   w_wide;
  logic signed [ACC_W-1:0] w_acc_sum, r_acc;
  logic                    w_acc_sat;
  ovf_reason_t             w_reason, r_sticky;

  logic                    r_s3_valid, r_s3_relu;
  logic signed [ACC_W-1:0] r_s3_sum;
  ovf_reason_t             r_s3_reason;

  logic [PW:0]             w_conv;
  logic                    w_out_sat, w_clamp;
  ovf_reason_t             w_out_reason;
  logic                    r_out_valid, r_out_ovf;
  logic [PW:0]             r_out_sum;

  // A full output register stalls the whole pipe, accumulator included.
  assign w_en          = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sm_mul_lane #(.W(W)) u_lane (
        .i_a    (bus.in_a[gi*W +: W]),
        .i_b    (bus.in_b[gi*W +: W]),
        .o_sign (w_l_sign[gi]),
        .o_mag  (w_l_mag[gi]),
        .o_ovf  (w_l_ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      r_s1_last  <= bus.in_last;
      r_s1_relu  <= bus.relu_en;
      r_s1_ovf   <= |w_l_ovf;
      r_s1_sign  <= w_l_sign;
      r_s1_mag   <= w_l_mag;
    end
  end

  always_comb begin
    w_s2_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_s2_sum = w_s2_sum + ACC_W'(sm_to_tc(r_s1_sign[i], word_t'(r_s1_mag[i])));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_relu  <= r_s1_relu;
      r_s2_ovf   <= r_s1_ovf;
      r_s2_sum   <= w_s2_sum;
    end
  end

  always_comb begin
    w_wide    = $signed({r_acc[ACC_W-1], r_acc}) + $signed({r_s2_sum[ACC_W-1], r_s2_sum});
    w_acc_sat = 1'b0;
    w_acc_sum = w_wide[ACC_W-1:0];
    if (w_wide > P_MAX) begin
      w_acc_sum = P_MAX[ACC_W-1:0];
      w_acc_sat = 1'b1;
    end else if (w_wide < P_MIN) begin
      w_acc_sum = P_MIN[ACC_W-1:0];
      w_acc_sat = 1'b1;
    end
    w_reason = r_sticky;
    if (w_reason == OVF_NONE) begin
      if (r_s2_ovf)       w_reason = OVF_UNITY;
      else if (w_acc_sat) w_reason = OVF_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_sticky   <= OVF_NONE;
      r_s3_valid <= 1'b0;
    end else if (w_en) begin
      r_s3_valid  <= r_s2_valid && r_s2_last;
      r_s3_sum    <= w_acc_sum;
      r_s3_relu   <= r_s2_relu;
      r_s3_reason <= w_reason;
      if (r_s2_valid) begin
        if (r_s2_last) begin
          r_acc    <= '0;
          r_sticky <= OVF_NONE;
        end else begin
          r_acc    <= w_acc_sum;
          r_sticky <= w_reason;
        end
      end
    end
  end

  // A ReLU-clamped result never counts as output saturation.
  always_comb begin
    w_out_sat    = 1'b0;
    w_conv       = PW1'(sat_tc_to_sm({{(MAX_W-ACC_W){r_s3_sum[ACC_W-1]}}, r_s3_sum}, PW, w_out_sat));
    w_clamp      = r_s3_relu && w_conv[PW];
    w_out_reason = r_s3_reason;
    if (w_out_reason == OVF_NONE && w_out_sat && !w_clamp) w_out_reason = OVF_OUT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_sum <= w_clamp ? '0 : w_conv;
        r_out_ovf <= (w_out_reason != OVF_NONE);
      end
    end
  end
endmodule

// File: tb/tb_sm_mac_pipe.sv
// Scoreboard bench: a value-level model predicts each vector's result; a monitor
// pops and compares every result the engine delivers.
`timescale 1ns/1ps
module tb_sm_mac_pipe;
  localparam int W     = 16;
  localparam int LANES = 1;
  localparam int ACC_W = 40;
  localparam longint ACC_LIM = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint OUT_LIM = (longint'(1) << (2*W-2)) - 1;

  typedef struct {
    logic [2*W-2:0] sum;
    bit             ovf;
    int             id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_mac_pipe_if #(.W(W), .LANES(LANES)) bus ();
  sm_mac_pipe #(.W(W), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random
  int vec_id   = 0;
  exp_t exp_q[$];
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  logic [2*W-2:0] last_sum;
  bit             last_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Operand value in units of 2^-(W-1); the unity code means +1.0.
  function automatic longint code_val(input logic [W-1:0] c);
    if (c[W-1] && c[W-2:0] == '0) return longint'(1) << (W-1);
    return c[W-1] ? -longint'(c[W-2:0]) : longint'(c[W-2:0]);
  endfunction

  task automatic model_beat(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                            input bit last, input bit relu);
    longint s = 0;
    longint p, mag;
    exp_t e;
    for (int l = 0; l < LANES; l++) begin
      p = code_val(a[l*W +: W]) * code_val(b[l*W +: W]);
      if (p > OUT_LIM) begin p = OUT_LIM; m_ovf = 1'b1; end
      s += p;
    end
    m_acc += s;
    if (m_acc > ACC_LIM) begin m_acc = ACC_LIM; m_ovf = 1'b1; end
    else if (m_acc < -ACC_LIM) begin m_acc = -ACC_LIM; m_ovf = 1'b1; end
    if (last) begin
      e.ovf = m_ovf;
      if (relu && m_acc < 0) begin
        e.sum = '0;
      end else begin
        mag = (m_acc < 0) ? -m_acc : m_acc;
        if (mag > OUT_LIM) begin mag = OUT_LIM; e.ovf = 1'b1; end
        e.sum = {(m_acc < 0), mag[2*W-3:0]};
      end
      e.id = vec_id++;
      exp_q.push_back(e);
      m_acc = 0;
      m_ovf = 1'b0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit last, input bit relu);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    bus.relu_en  = relu;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      model_beat(a, b, last, relu);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_last(input string name, input logic [2*W-2:0] sum, input bit ovf);
    check(name, {32'd0, last_ovf, last_sum}, {32'd0, ovf, sum});
  endtask

  function automatic logic [W-1:0] rnd_code();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : ready_gen
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    logic [2*W-2:0] held_sum;
    bit             held_ovf;
    bit             stalled = 1'b0;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (bus.out_valid) begin
        if (stalled) check("held_result", {32'd0, bus.out_ovf, bus.out_sum}, {32'd0, held_ovf, held_sum});
        if (bus.out_ready) begin
          stalled = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result actual=0x%08h required=none", bus.out_sum);
          end else begin
            e = exp_q.pop_front();
            $display("tb: result %0d sum=0x%08h ovf=%0b", e.id, bus.out_sum, bus.out_ovf);
            if (bus.out_sum !== e.sum || bus.out_ovf !== e.ovf) begin
              failures++;
              $display("FAIL result%0d actual sum=0x%08h ovf=%0b required sum=0x%08h ovf=%0b",
                       e.id, bus.out_sum, bus.out_ovf, e.sum, e.ovf);
            end
          end
          last_sum = bus.out_sum;
          last_ovf = bus.out_ovf;
        end else begin
          stalled  = 1'b1;
          held_sum = bus.out_sum;
          held_ovf = bus.out_ovf;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.relu_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
    @(posedge clk); #1;
    rdy_mode = 1;

    // Single-beat vector and its latency.
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("latency_edge%0d", k + 1), 64'(bus.out_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    drain();
    expect_last("half_sq", 31'h10000000, 1'b0);

    send(16'h8000, 16'h1234, 1'b1, 1'b0);
    drain();
    expect_last("unity", 31'h091A0000, 1'b0);
    send(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    drain();
    expect_last("zero", 31'h00000000, 1'b0);

    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    send(16'hC000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_last("three_beat", 31'h10000000, 1'b0);
    send(16'hC000, 16'h4000, 1'b1, 1'b1);
    drain();
    expect_last("relu_clamp", 31'h00000000, 1'b0);
    send(16'hC000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_last("negative", 31'h50000000, 1'b0);
    send(16'hC000, 16'h4000, 1'b0, 1'b1);
    send(16'hC000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_last("relu_last_only", 31'h60000000, 1'b0);

    for (int i = 0; i < 8; i++) send(16'h8000, 16'h8000, i == 7, 1'b0);
    drain();
    expect_last("saturate", 31'h3FFFFFFF, 1'b1);
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_last("ovf_cleared", 31'h10000000, 1'b0);

    // Backpressure: results pile up while the consumer is not ready.
    rdy_mode = 0;
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    send(16'h8000, 16'h1234, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
    check("stall_in_ready",  64'(bus.in_ready),  64'd0);
    @(posedge clk); #1;
    fork
      send(16'h2000, 16'h2000, 1'b1, 1'b0);
    join_none
    repeat (4) begin @(posedge clk); #1; end
    rdy_mode = 1;
    wait fork;
    drain();
    expect_last("after_stall", 31'h04000000, 1'b0);

    // Reset in the middle of a vector.
    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_last("after_reset", 31'h10000000, 1'b0);

    // Random vectors with bubbles and random backpressure.
    rdy_mode = 2;
    for (int v = 0; v < 60; v++) begin
      int len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        send(rnd_code(), rnd_code(), b == len - 1, 1'($urandom_range(0, 1)));
      end
    end
    rdy_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
